// File: rtl/mac_share_arbiter_if.sv
// Bundle of requester-side and MAC-side signals for mac_share_arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface mac_share_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*512-1:0] req_a_flat;
    logic [NUM_REQ*512-1:0] req_b_flat;
    logic [NUM_REQ*16-1:0]  req_bias;
    logic [NUM_REQ-1:0]     ack;
    logic [15:0]            resp_result;
    logic                   resp_err;
    logic [NUM_REQ-1:0]     grant;
    logic                   busy;
    logic                   mac_start;
    logic [511:0]           mac_a_flat;
    logic [511:0]           mac_b_flat;
    logic [15:0]            mac_bias;
    logic [15:0]            mac_result;
    logic                   mac_done;

    modport slave (
        input  req, req_a_flat, req_b_flat, req_bias, mac_result, mac_done,
        output ack, resp_result, resp_err, grant, busy, mac_start,
               mac_a_flat, mac_b_flat, mac_bias
    );

    modport master (
        output req, req_a_flat, req_b_flat, req_bias, mac_result, mac_done,
        input  ack, resp_result, resp_err, grant, busy, mac_start,
               mac_a_flat, mac_b_flat, mac_bias
    );
endinterface

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter sharing one pipelined MAC among NUM_REQ requesters,
// with per-operation timeout and a registered response to the served requester.
module mac_share_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                clk,
    input logic                rst,
    mac_share_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]   TOUT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] GRANT_LSB  = NUM_REQ'(1'b1);
    localparam logic [IDX_W-1:0]   LAST_RESET = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   sel_s;
    logic               take_s, done_s, tout_s;
    logic [NUM_REQ-1:0] grant_q, ack_q;
    logic               busy_q, mac_start_q, resp_err_q;
    logic [15:0]        resp_result_q, bias_q;
    logic [511:0]       a_q, b_q;

    // First set request bit at or after last+1, wrapping around NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        int               cand;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = int'(last) + k;
            cand     = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
            cand_idx = cand[IDX_W-1:0];
            if (!found && r[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Next-state, timeout counter and transition qualifiers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_s  = 1'b0;
        done_s  = 1'b0;
        tout_s  = 1'b0;
        sel_s   = rr_pick(bus.req, last_q);
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    take_s  = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the timeout cycle still counts as success.
                if (bus.mac_done) begin
                    done_s  = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == TOUT_LAST) begin
                    tout_s  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, ownership, operand latches and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_q        <= LAST_RESET;
            grant_q       <= '0;
            ack_q         <= '0;
            busy_q        <= 1'b0;
            mac_start_q   <= 1'b0;
            resp_result_q <= 16'h0000;
            resp_err_q    <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            bias_q        <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != S_IDLE);
            mac_start_q <= (state_d == S_ISSUE);
            ack_q       <= (state_d == S_RESP) ? grant_q : '0;
            if (take_s) begin
                grant_q <= GRANT_LSB << sel_s;
                last_q  <= sel_s;
                a_q     <= bus.req_a_flat[int'(sel_s)*512 +: 512];
                b_q     <= bus.req_b_flat[int'(sel_s)*512 +: 512];
                bias_q  <= bus.req_bias[int'(sel_s)*16 +: 16];
            end else if (state_q == S_RESP) begin
                grant_q <= '0;
            end
            if (done_s) begin
                resp_result_q <= bus.mac_result;
                resp_err_q    <= 1'b0;
            end else if (tout_s) begin
                resp_result_q <= 16'h0000;
                resp_err_q    <= 1'b1;
            end
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.mac_start   = mac_start_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.mac_a_flat  = a_q;
    assign bus.mac_b_flat  = b_q;
    assign bus.mac_bias    = bias_q;
endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed and randomized bench for mac_share_arbiter; a round-robin reference
// model and a scripted MAC responder supply every expected value.
module tb_mac_share_arbiter;
    localparam int NR = 3;
    localparam int TO = 255;

    logic clk;
    logic rst;
    int   checks  = 0;
    int   errors  = 0;
    int   rr_last = NR - 1;

    mac_share_arbiter_if #(.NUM_REQ(NR)) bif();

    mac_share_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1039:0] obs, input logic [1039:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration rule: first requester at or after last+1 (mod NR).
    function automatic int rr_pick(input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            if (r[(rr_last + k) % NR]) return (rr_last + k) % NR;
        end
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NR * 16; i++) begin
            bif.req_a_flat[i*32 +: 32] = $urandom;
            bif.req_b_flat[i*32 +: 32] = $urandom;
        end
        for (int i = 0; i < NR; i++) bif.req_bias[i*16 +: 16] = 16'($urandom);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bif.req      = '0;
        bif.mac_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        rr_last = NR - 1;
    endtask

    // One operation, starting in an IDLE cycle with req already driven.
    // lat = MAC latency in cycles after mac_start; lat outside 1..TO means no done.
    task automatic run_txn(input int lat, input logic [15:0] res, input int drop_t);
        int owner, t, t_exp, starts;
        bit got_ack, tmo;
        logic [NR-1:0]  oh;
        logic [1039:0]  ops;
        owner   = rr_pick(bif.req);
        rr_last = owner;
        oh      = '0;
        oh[owner] = 1'b1;
        ops     = {bif.req_a_flat[owner*512 +: 512], bif.req_b_flat[owner*512 +: 512],
                   bif.req_bias[owner*16 +: 16]};
        tmo     = (lat < 1) || (lat > TO);
        t_exp   = tmo ? TO + 3 : lat + 3;
        t       = 1;
        starts  = 0;
        got_ack = 1'b0;
        while (!got_ack && t < t_exp + 10) begin
            @(negedge clk);
            t++;
            bif.mac_done   = 1'b0;
            bif.mac_result = 16'($urandom);
            if (bif.mac_start) starts++;
            chk("grant", bif.grant, oh);
            chk("busy", bif.busy, 1'b1);
            chk("operands", {bif.mac_a_flat, bif.mac_b_flat, bif.mac_bias}, ops);
            if (bif.ack != '0) begin
                got_ack = 1'b1;
                chk("ack", bif.ack, oh);
                chk("ack_cycle", t, t_exp);
                chk("mac_start_count", starts, 1);
                chk("resp_result", bif.resp_result, tmo ? 16'h0000 : res);
                chk("resp_err", bif.resp_err, tmo);
            end
            if (t == 3) rand_ops();
            if (t == drop_t) bif.req[owner] = 1'b0;
            if (!tmo && t == lat + 2) begin
                bif.mac_done   = 1'b1;
                bif.mac_result = res;
            end
        end
        chk("ack_seen", got_ack, 1'b1);
        @(negedge clk);
        chk("ack_clear", bif.ack, 0);
        chk("grant_clear", bif.grant, 0);
        chk("busy_clear", bif.busy, 0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        bif.req_a_flat = '0;
        bif.req_b_flat = '0;
        bif.req_bias   = '0;
        bif.mac_result = 16'h0000;
        do_reset();

        // Reset state
        chk("rst_ack", bif.ack, 0);
        chk("rst_grant", bif.grant, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_mac_start", bif.mac_start, 0);
        chk("rst_resp", {bif.resp_err, bif.resp_result}, 0);
        chk("rst_operands", {bif.mac_a_flat, bif.mac_b_flat, bif.mac_bias}, 0);

        // Single request, latency 5 -> ack on cycle 8
        bif.req_a_flat = {(NR*32){16'h0100}};
        bif.req_b_flat = {(NR*32){16'h0100}};
        bif.req_bias   = '0;
        bif.req        = 3'b010;
        run_txn(5, 16'h0020, 0);

        // Stray mac_done in IDLE is ignored and the response holds
        bif.req        = '0;
        bif.mac_done   = 1'b1;
        bif.mac_result = 16'h5555;
        @(negedge clk);
        bif.mac_done   = 1'b0;
        @(negedge clk);
        chk("hold_result", bif.resp_result, 16'h0020);
        chk("hold_err", bif.resp_err, 1'b0);
        chk("stray_done_busy", bif.busy, 1'b0);
        chk("stray_done_ack", bif.ack, 0);

        // Contention from reset: rotation 0,1,2,0,1,2
        do_reset();
        bif.req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            run_txn($urandom_range(1, 6), 16'($urandom), 0);
        end

        // Timeout, then a normal operation
        bif.req = 3'b001;
        run_txn(0, 16'h0000, 0);
        bif.req = 3'b100;
        run_txn(4, 16'h1234, 0);

        // Completion on the timeout cycle wins
        bif.req = 3'b010;
        run_txn(TO, 16'hFFF0, 0);

        // Requester 2 withdraws in WAIT
        bif.req = 3'b100;
        rand_ops();
        run_txn(6, 16'h0BEE, 4);

        // Reset two cycles after mac_start; late done afterwards
        bif.req = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (bif.mac_start) seen = 1'b1;
        end
        chk("rst_wait_mac_start_seen", seen, 1'b1);
        bif.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        rr_last        = NR - 1;
        bif.mac_done   = 1'b1;
        bif.mac_result = 16'h7777;
        @(negedge clk);
        bif.mac_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rst_wait_ack", bif.ack, 0);
            chk("rst_wait_grant", bif.grant, 0);
            chk("rst_wait_busy", bif.busy, 0);
            chk("rst_wait_mac_start", bif.mac_start, 0);
            @(negedge clk);
        end
        chk("rst_wait_resp", {bif.resp_err, bif.resp_result}, 0);
        chk("rst_wait_operands", {bif.mac_a_flat, bif.mac_b_flat, bif.mac_bias}, 0);
        bif.req = 3'b111;
        run_txn(3, 16'h0042, 0);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            bif.req = NR'($urandom_range(1, (1 << NR) - 1));
            rand_ops();
            if ($urandom_range(0, 1) == 1) begin
                bif.mac_done   = 1'b1;
                bif.mac_result = 16'hDEAD;
            end
            lat = $urandom_range(1, 10);
            run_txn(lat, 16'($urandom), ($urandom_range(0, 1) == 1) ? 4 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_share_arbiter.md
MAC_SHARE_ARBITER -- requirements
Module: mac_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters sharing one pipelined_mac.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, the maximum number of WAIT cycles before an operation is aborted.
REQ-003 SHALL have port clk  input  1  single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester request level, bit i = requester i.
REQ-006 SHALL have port req_a_flat  input  NUM_REQ*512  per-requester activations, 32x16-bit signed, slice i = bits [i*512 +: 512].
REQ-007 SHALL have port req_b_flat  input  NUM_REQ*512  per-requester weights, same packing as req_a_flat.
REQ-008 SHALL have port req_bias  input  NUM_REQ*16  per-requester signed bias, slice i = bits [i*16 +: 16].
REQ-009 SHALL have port ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-010 SHALL have port resp_result  output  16  signed result of the completed operation.
REQ-011 SHALL have port resp_err  output  1  high together with ack when the operation timed out.
REQ-012 SHALL have port grant  output  NUM_REQ  one-hot owner of the MAC, zero when idle.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port mac_start  output  1  start pulse to pipelined_mac.
REQ-015 SHALL have port mac_a_flat  output  512  latched activations to the MAC.
REQ-016 SHALL have port mac_b_flat  output  512  latched weights to the MAC.
REQ-017 SHALL have port mac_bias  output  16  latched bias to the MAC.
REQ-018 SHALL have port mac_result  input  16  signed result from the MAC.
REQ-019 SHALL have port mac_done  input  1  completion pulse from the MAC.

Function
REQ-020 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE with req!=0, SHALL select the first set req bit searching upward, with wrap, from (last_grant+1) mod NUM_REQ.
REQ-022 In that same IDLE cycle, SHALL latch the selected slices into mac_a_flat, mac_b_flat and mac_bias, set grant, update last_grant, and go to ISSUE.
REQ-023 In ISSUE, SHALL assert mac_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-024 mac operands SHALL remain stable from ISSUE until the return to IDLE.
REQ-025 In WAIT, when mac_done=1, SHALL register mac_result into resp_result, set resp_err=0, and go to RESP.
REQ-026 In WAIT, the counter SHALL increment each cycle without mac_done.
REQ-027 When the counter equals TIMEOUT_CYC without mac_done, SHALL set resp_result=0 and resp_err=1, and go to RESP.
REQ-028 If mac_done and the timeout coincide, mac_done SHALL win.
REQ-029 In RESP, SHALL pulse ack[grant index] for one cycle, then clear grant and return to IDLE.
REQ-030 resp_result and resp_err SHALL hold until the next RESP.
REQ-031 Latency from a lone request in IDLE to ack SHALL be (MAC latency + 3) cycles: 1 IDLE + 1 ISSUE + L WAIT + 1 RESP.
REQ-032 A requester dropping req after grant SHALL NOT abort the operation; ack still pulses.
REQ-033 A requester that keeps req high after ack SHALL be re-eligible only via round-robin order; at least one IDLE cycle SHALL occur between back-to-back grants.
REQ-034 mac_done seen outside WAIT SHALL be ignored.
REQ-035 NUM_REQ=1 SHALL degenerate to always granting requester 0.
REQ-036 Requesters SHALL never starve: with all req high, grants SHALL rotate 0,1,2,0,...

Reset
REQ-037 On rst=1 at a clock edge, SHALL enter IDLE and set ack=0, grant=0, busy=0, mac_start=0, resp_result=0, resp_err=0, counter=0, and last_grant=NUM_REQ-1 (so requester 0 is first).
REQ-038 Reset mid-operation SHALL abandon the operation with no ack, and SHALL ignore any later mac_done from it.
REQ-039 Latched MAC operands SHALL reset to 0.

Verification
REQ-040 Single request: req=3'b010, a=all 16'h0100, b=all 16'h0100, bias=0, MAC model returns 16'h0020 after 5 cycles -> grant=3'b010, one mac_start pulse, ack=3'b010 on cycle 8, resp_result=16'h0020, resp_err=0.
REQ-041 Contention: req=3'b111 held for 6 operations from reset -> grant order 0,1,2,0,1,2; each ack one cycle, one-hot.
REQ-042 Timeout: MAC model never asserts done -> ack after TIMEOUT_CYC WAIT cycles with resp_err=1, resp_result=0; the next request is served normally.
REQ-043 Coincidence: mac_done on the timeout cycle with result 16'hFFF0 -> resp_err=0, resp_result=16'hFFF0.
REQ-044 Reset in WAIT: rst asserted two cycles after mac_start, late mac_done delivered afterwards -> no ack, grant=0, busy=0, state IDLE.
REQ-045 Request withdrawn: req[2] dropped in WAIT -> ack[2] still pulses, and operands stay stable through WAIT.
